// File: rtl/sample_uart_tx.sv
// Sample RAM readout over UART 8N1: header byte, then each sample as a high byte and a low byte.
// A byte FSM fetches samples from a registered RAM and feeds a single-frame bit engine.
module sample_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned DEPTH        = 512,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_en,
  output logic                  o_tx_ready,
  output logic [ADDR_WIDTH-1:0] o_read_address,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  o_uart_tx,
  output logic                  o_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] SampleLast = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StFetch,
    StWaitData,
    StSendHi,
    StSendLo,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;

  logic                    busy_q, busy_d;
  logic                    tx_q, tx_d;
  logic [3:0]              bit_idx_q, bit_idx_d;
  logic [CntW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [7:0]              byte_q, byte_d;

  logic                    load;
  logic [7:0]              load_byte;
  logic                    bit_done;
  logic [DATA_WIDTH-1:0]   byte_src;
  logic [15:0]             byte_src_ext;

  // High byte comes straight from the RAM in WAIT_DATA; low byte from the latch afterwards.
  assign byte_src     = (state_q == StWaitData) ? i_read_data : sample_q;
  assign byte_src_ext = 16'(byte_src);

  assign bit_done = busy_q && (bit_idx_q == 4'd9) && (clk_cnt_q == BitLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sample_d  = sample_q;
    load      = 1'b0;
    load_byte = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (i_tx_en) begin
          load      = 1'b1;
          load_byte = HEADER_BYTE;
          cnt_d     = '0;
          addr_d    = '0;
          state_d   = StHeader;
        end
      end
      StHeader: begin
        if (bit_done) begin
          addr_d  = cnt_q;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StWaitData;
      StWaitData: begin
        sample_d  = i_read_data;
        load      = 1'b1;
        load_byte = byte_src_ext[15:8];
        state_d   = StSendHi;
      end
      StSendHi: begin
        if (bit_done) begin
          load      = 1'b1;
          load_byte = byte_src_ext[7:0];
          state_d   = StSendLo;
        end
      end
      StSendLo: begin
        if (bit_done) begin
          // Terminate on the compare so a full-range DEPTH never wraps the address.
          if (cnt_q == SampleLast) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = cnt_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bit engine: a load always wins, so a frame can start in the done cycle of the previous one.
  always_comb begin
    busy_d    = busy_q;
    tx_d      = tx_q;
    bit_idx_d = bit_idx_q;
    clk_cnt_d = clk_cnt_q;
    byte_d    = byte_q;
    if (load) begin
      busy_d    = 1'b1;
      tx_d      = 1'b0;
      bit_idx_d = 4'd0;
      clk_cnt_d = '0;
      byte_d    = load_byte;
    end else if (busy_q) begin
      if (clk_cnt_q == BitLast) begin
        clk_cnt_d = '0;
        if (bit_idx_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
          tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : byte_q[bit_idx_q[2:0]];
        end
      end else begin
        clk_cnt_d = clk_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      sample_q  <= '0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
      bit_idx_q <= 4'd0;
      clk_cnt_q <= '0;
      byte_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sample_q  <= sample_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      bit_idx_q <= bit_idx_d;
      clk_cnt_q <= clk_cnt_d;
      byte_q    <= byte_d;
    end
  end

  assign o_tx_ready     = (state_q == StIdle);
  assign o_done         = (state_q == StDone);
  assign o_read_address = addr_q;
  assign o_uart_tx      = tx_q;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench for sample_uart_tx: two instances (DEPTH=2 and a full-range DEPTH=4),
// UART decode of the line and cycle-exact o_done timing.
module tb_sample_uart_tx;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tx_en_a, tx_en_b;
  logic        ready_a, uart_a, done_a;
  logic        ready_b, uart_b, done_b;
  logic [8:0]  addr_a;
  logic [1:0]  addr_b;
  logic [11:0] rdata_a, rdata_b;

  logic [11:0] ram_a [512];
  logic [11:0] ram_b [4];

  int checks = 0;
  int errors = 0;

  bit          sel_b = 1'b0;
  logic        rx_line;
  logic [7:0]  rx_byte;
  logic [7:0]  rx_q [$];
  logic        line_samp [41];
  logic [1:0]  addr_log [$];

  logic [7:0] exp_a [5] = '{8'hA5, 8'h0A, 8'hBC, 8'h01, 8'h23};
  logic [7:0] exp_b [9] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};

  sample_uart_tx #(
    .CLKS_PER_BIT(4), .ADDR_WIDTH(9), .DATA_WIDTH(12), .DEPTH(2), .HEADER_BYTE(8'hA5)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_tx_en(tx_en_a), .o_tx_ready(ready_a),
    .o_read_address(addr_a), .i_read_data(rdata_a), .o_uart_tx(uart_a), .o_done(done_a)
  );

  sample_uart_tx #(
    .CLKS_PER_BIT(4), .ADDR_WIDTH(2), .DATA_WIDTH(12), .DEPTH(4), .HEADER_BYTE(8'hA5)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_tx_en(tx_en_b), .o_tx_ready(ready_b),
    .o_read_address(addr_b), .i_read_data(rdata_b), .o_uart_tx(uart_b), .o_done(done_b)
  );

  always_ff @(posedge clk) begin
    rdata_a <= ram_a[addr_a];
    rdata_b <= ram_b[addr_b];
  end

  assign rx_line = sel_b ? uart_b : uart_a;

  // UART receiver for CLKS_PER_BIT=4: sample each bit at its third cycle.
  always begin
    @(negedge clk);
    if (rx_line === 1'b0 && rst === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        rx_byte[i] = rx_line;
      end
      repeat (4) @(negedge clk);
      rx_q.push_back(rx_byte);
    end
  end

  // Pulse i_tx_en and run until o_done (cycle counted from the i_tx_en cycle) or the budget ends.
  task automatic do_transfer(input bit on_b, input int extra_pulse, input int max_cyc,
                             output int done_cyc, output bit ready_low_ok,
                             output bit ready_after);
    logic cur_ready, cur_done;
    done_cyc     = -1;
    ready_low_ok = 1'b1;
    ready_after  = 1'b0;
    @(posedge clk); #1;
    if (on_b) tx_en_b = 1'b1; else tx_en_a = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      if (on_b) tx_en_b = (c == extra_pulse); else tx_en_a = (c == extra_pulse);
      cur_ready = on_b ? ready_b : ready_a;
      cur_done  = on_b ? done_b : done_a;
      if (c <= 40) line_samp[c] = rx_line;
      if (on_b && (addr_log.size() == 0 || addr_log[$] != addr_b)) addr_log.push_back(addr_b);
      if (cur_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (cur_ready !== 1'b0) ready_low_ok = 1'b0;
    end
    @(posedge clk); #1;
    tx_en_a = 1'b0;
    tx_en_b = 1'b0;
    ready_after = on_b ? ready_b : ready_a;
  endtask

  task automatic test_reset();
    bit idle_ok;
    rst = 1'b1; tx_en_a = 1'b0; tx_en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uart_a !== 1'b1) begin errors++; $display("FAIL reset_uart_a got %b want 1", uart_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a got %b want 1", ready_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b want 0", done_a); end
    checks++; if (addr_a !== 9'd0) begin errors++; $display("FAIL reset_addr_a got %0d want 0", addr_a); end
    checks++; if (uart_b !== 1'b1) begin errors++; $display("FAIL reset_uart_b got %b want 1", uart_b); end
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %b want 1", ready_b); end
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      if (uart_a !== 1'b1 || uart_b !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0) idle_ok = 1'b0;
    end
    checks++; if (!idle_ok) begin errors++; $display("FAIL idle_line got activity want steady high"); end
  endtask

  task automatic test_bit_timing();
    int dc; bit rl, ra;
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    sel_b = 1'b0;
    do_transfer(1'b0, 0, 400, dc, rl, ra);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (line_samp[b*4 + k + 1] !== exp_bits[b]) begin
          errors++;
          $display("FAIL bit_timing bit %0d cycle %0d got %b want %b", b, k,
                   line_samp[b*4 + k + 1], exp_bits[b]);
        end
      end
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_basic(input int extra_pulse, input string tag);
    int dc; bit rl, ra;
    sel_b = 1'b0;
    rx_q.delete();
    do_transfer(1'b0, extra_pulse, 400, dc, rl, ra);
    checks++; if (dc != 205) begin errors++; $display("FAIL %s done_cycle got %0d want 205", tag, dc); end
    checks++; if (!rl) begin errors++; $display("FAIL %s ready_during got high want low", tag); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL %s ready_after got %b want 1", tag, ra); end
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL %s byte_count got %0d want 5", tag, rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== exp_a[i]) begin
          errors++; $display("FAIL %s byte%0d got %h want %h", tag, i, rx_q[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    bit quiet_ok;
    test_basic(100, "ignored_start");
    quiet_ok = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
      if (uart_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0) quiet_ok = 1'b0;
    end
    checks++; if (!quiet_ok) begin errors++; $display("FAIL no_second_transfer got activity want idle"); end
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL no_extra_bytes got %0d want 5", rx_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic line_before;
    sel_b = 1'b0;
    line_before = 1'bx;
    @(posedge clk); #1;
    tx_en_a = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      @(posedge clk); #1;
      tx_en_a = 1'b0;
      if (c == 55) line_before = uart_a;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (line_before !== 1'b0) begin errors++; $display("FAIL mid_frame_line got %b want 0", line_before); end
    checks++; if (uart_a !== 1'b1) begin errors++; $display("FAIL reset_mid_uart got %b want 1", uart_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b want 1", ready_a); end
    checks++; if (addr_a !== 9'd0) begin errors++; $display("FAIL reset_mid_addr got %0d want 0", addr_a); end
    repeat (60) @(posedge clk);
    test_basic(0, "restart");
  endtask

  task automatic test_wrap();
    int dc; bit rl, ra;
    sel_b = 1'b1;
    rx_q.delete();
    addr_log.delete();
    do_transfer(1'b1, 0, 600, dc, rl, ra);
    repeat (50) begin
      @(posedge clk); #1;
      if (addr_log[$] != addr_b) addr_log.push_back(addr_b);
    end
    checks++; if (dc != 369) begin errors++; $display("FAIL wrap_done_cycle got %0d want 369", dc); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL wrap_ready_after got %b want 1", ra); end
    checks++; if (addr_b !== 2'd3) begin errors++; $display("FAIL wrap_final_addr got %0d want 3", addr_b); end
    checks++;
    if (addr_log.size() != 4) begin
      errors++; $display("FAIL wrap_addr_count got %0d want 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_log[i] !== 2'(i)) begin
          errors++; $display("FAIL wrap_addr%0d got %0d want %0d", i, addr_log[i], i);
        end
      end
    end
    checks++;
    if (rx_q.size() != 9) begin
      errors++; $display("FAIL wrap_byte_count got %0d want 9", rx_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_q[i] !== exp_b[i]) begin
          errors++; $display("FAIL wrap_byte%0d got %h want %h", i, rx_q[i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram_a[i] = 12'h000;
    ram_a[0] = 12'hABC;
    ram_a[1] = 12'h123;
    for (int i = 0; i < 4; i++) ram_b[i] = 12'(i);
    test_reset();
    test_bit_timing();
    test_basic(0, "basic");
    test_ignored_start();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
